// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared pipeline constants, mul/div state type and latency helper
package mips_pipe_pkg;
    localparam int REG_ADDR_W  = 5;
    localparam int MUL_LAT_DEF = 4;
    localparam int DIV_LAT_DEF = 32;

    typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

    // Counter preload so the unit stays busy for exactly the given latency
    function automatic logic [7:0] md_load(logic is_div, int mul_lat, int div_lat);
        return 8'(is_div ? div_lat - 1 : mul_lat - 1);
    endfunction
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: decode/execute hazard inputs and front-end control outputs
interface hazard_ctrl_if;
    import mips_pipe_pkg::*;
    logic [REG_ADDR_W-1:0] id_rs_addr;
    logic [REG_ADDR_W-1:0] id_rt_addr;
    logic                  id_uses_rs;
    logic                  id_uses_rt;
    logic                  id_is_muldiv;
    logic                  id_is_div;
    logic                  id_reads_hilo;
    logic [REG_ADDR_W-1:0] ex_rt_addr;
    logic                  ex_mem_read;
    logic                  ex_branch_taken;
    logic                  pc_write;
    logic                  if_id_write;
    logic                  if_id_flush;
    logic                  id_ex_flush;
    logic                  md_start;
    logic                  md_busy;
    logic                  md_done;
    logic [31:0]           stall_cnt;

    modport master (
        output id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt, id_is_muldiv, id_is_div,
               id_reads_hilo, ex_rt_addr, ex_mem_read, ex_branch_taken,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush, md_start, md_busy, md_done,
               stall_cnt
    );

    modport slave (
        input  id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt, id_is_muldiv, id_is_div,
               id_reads_hilo, ex_rt_addr, ex_mem_read, ex_branch_taken,
        output pc_write, if_id_write, if_id_flush, id_ex_flush, md_start, md_busy, md_done,
               stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl_md_timer.sv
// md_timer: tracks the multi-cycle mul/div unit, busy for exactly its latency after a start
module md_timer
    import mips_pipe_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic md_start,
    input  logic is_div,
    output logic md_busy,
    output logic md_done
);
    md_state_t  state, state_nxt;
    logic [7:0] cnt, cnt_nxt;

    // State and countdown registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Load the latency on start, count down while busy, leave on the zero count
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (state == MD_IDLE) begin
            state_nxt = md_start ? MD_BUSY : MD_IDLE;
            cnt_nxt   = md_start ? md_load(is_div, MUL_LAT, DIV_LAT) : cnt;
        end else begin
            state_nxt = (cnt == 8'd0) ? MD_IDLE : MD_BUSY;
            cnt_nxt   = (cnt == 8'd0) ? cnt : cnt - 8'd1;
        end
    end

    assign md_busy = (state == MD_BUSY);
    assign md_done = md_busy && (cnt == 8'd0);
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / mul-div stall, taken-branch flush and stall-cycle counter
module hazard_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input logic         clk,
    input logic         rst_n,
    hazard_ctrl_if.slave hz
);
    logic load_use, md_hazard, stall, md_start, md_busy, md_done;

    assign load_use  = hz.ex_mem_read && (hz.ex_rt_addr != '0) &&
                       ((hz.id_uses_rs && hz.ex_rt_addr == hz.id_rs_addr) ||
                        (hz.id_uses_rt && hz.ex_rt_addr == hz.id_rt_addr));
    assign md_hazard = md_busy && (hz.id_is_muldiv || hz.id_reads_hilo);
    assign stall     = (load_use || md_hazard) && !hz.ex_branch_taken;
    assign md_start  = rst_n && hz.id_is_muldiv && !stall && !hz.ex_branch_taken;

    // Front-end control: flush beats stall beats run; reset holds the pipe in a bubble
    always_comb begin
        hz.pc_write    = rst_n && !stall;
        hz.if_id_write = rst_n && !stall;
        hz.if_id_flush = !rst_n || hz.ex_branch_taken;
        hz.id_ex_flush = !rst_n || hz.ex_branch_taken || stall;
    end

    md_timer #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) u_md_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .md_start (md_start),
        .is_div   (hz.id_is_div),
        .md_busy  (md_busy),
        .md_done  (md_done)
    );

    assign hz.md_start = md_start;
    assign hz.md_busy  = md_busy;
    assign hz.md_done  = md_done;

    // Saturating count of stall cycles; flush cycles are not stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hz.stall_cnt <= '0;
        else if (stall && hz.stall_cnt != 32'hFFFF_FFFF)
            hz.stall_cnt <= hz.stall_cnt + 32'd1;
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and random checks of hazard_ctrl against a cycle-indexed model
module tb_hazard_ctrl;
    localparam int MUL = 4;
    localparam int DIV = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    hazard_ctrl_if hz();

    hazard_ctrl #(.MUL_LAT(MUL), .DIV_LAT(DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the unit is busy on every cycle index up to busy_end
    int          cyc = 0;
    int          busy_end = -1;
    logic [31:0] m_cnt = '0;
    logic        m_stall = 1'b0;
    logic        m_start = 1'b0;
    logic        m_div = 1'b0;

    always @(negedge clk) begin
        logic lu, mbusy;
        if (!rst_n) begin
            busy_end = -1;
            m_cnt    = '0;
        end
        lu = hz.ex_mem_read && hz.ex_rt_addr != 0 &&
             ((hz.id_uses_rs && hz.ex_rt_addr == hz.id_rs_addr) ||
              (hz.id_uses_rt && hz.ex_rt_addr == hz.id_rt_addr));
        mbusy   = rst_n && cyc <= busy_end;
        m_stall = rst_n && (lu || (mbusy && (hz.id_is_muldiv || hz.id_reads_hilo))) && !hz.ex_branch_taken;
        m_start = rst_n && hz.id_is_muldiv && !m_stall && !hz.ex_branch_taken;
        m_div   = hz.id_is_div;
        chk("pc_write", 32'(hz.pc_write), 32'(rst_n && !m_stall));
        chk("if_id_write", 32'(hz.if_id_write), 32'(rst_n && !m_stall));
        chk("if_id_flush", 32'(hz.if_id_flush), 32'(!rst_n || hz.ex_branch_taken));
        chk("id_ex_flush", 32'(hz.id_ex_flush), 32'(!rst_n || hz.ex_branch_taken || m_stall));
        chk("md_start", 32'(hz.md_start), 32'(m_start));
        chk("md_busy", 32'(hz.md_busy), 32'(mbusy));
        chk("md_done", 32'(hz.md_done), 32'(rst_n && cyc == busy_end));
        chk("stall_cnt", hz.stall_cnt, m_cnt);
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            busy_end = -1;
            m_cnt    = '0;
        end else begin
            if (m_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (m_start) busy_end = cyc + (m_div ? DIV : MUL);
        end
        cyc++;
    end

    task automatic idle_in();
        hz.id_rs_addr = 0; hz.id_rt_addr = 0; hz.id_uses_rs = 0; hz.id_uses_rt = 0;
        hz.id_is_muldiv = 0; hz.id_is_div = 0; hz.id_reads_hilo = 0;
        hz.ex_rt_addr = 0; hz.ex_mem_read = 0; hz.ex_branch_taken = 0;
    endtask

    task automatic next_cyc();
        @(posedge clk); #1;
    endtask

    task automatic at_neg();
        @(negedge clk); #1;
    endtask

    initial begin
        int n;
        idle_in();
        at_neg();
        chk("rst pc_write", 32'(hz.pc_write), 0);
        chk("rst if_id_flush", 32'(hz.if_id_flush), 1);
        chk("rst id_ex_flush", 32'(hz.id_ex_flush), 1);
        chk("rst stall_cnt", hz.stall_cnt, 0);
        next_cyc(); rst_n = 1;
        hz.ex_mem_read = 1; hz.ex_rt_addr = 5; hz.id_rs_addr = 5; hz.id_uses_rs = 1;
        at_neg();
        chk("lu pc_write", 32'(hz.pc_write), 0);
        chk("lu id_ex_flush", 32'(hz.id_ex_flush), 1);
        next_cyc(); idle_in();
        at_neg();
        chk("lu stall_cnt", hz.stall_cnt, 1);
        next_cyc();
        hz.ex_mem_read = 1; hz.ex_rt_addr = 0; hz.id_rs_addr = 0; hz.id_uses_rs = 1;
        at_neg();
        chk("rt0 pc_write", 32'(hz.pc_write), 1);
        next_cyc();
        hz.ex_rt_addr = 7; hz.id_rs_addr = 7; hz.id_rt_addr = 7; hz.id_uses_rs = 0; hz.id_uses_rt = 0;
        at_neg();
        chk("nouse id_ex_flush", 32'(hz.id_ex_flush), 0);
        next_cyc();
        hz.id_uses_rt = 1; hz.ex_branch_taken = 1;
        at_neg();
        chk("br pc_write", 32'(hz.pc_write), 1);
        chk("br if_id_flush", 32'(hz.if_id_flush), 1);
        next_cyc(); idle_in();
        at_neg();
        chk("br stall_cnt", hz.stall_cnt, 1);
        next_cyc();
        hz.id_is_muldiv = 1;
        at_neg();
        chk("mul md_start", 32'(hz.md_start), 1);
        next_cyc(); idle_in(); hz.id_reads_hilo = 1;
        for (int k = 1; k <= 5; k++) begin
            at_neg();
            chk("mfhi pc_write", 32'(hz.pc_write), 32'(k == 5));
            chk("mfhi md_busy", 32'(hz.md_busy), 32'(k < 5));
            chk("mfhi md_done", 32'(hz.md_done), 32'(k == 4));
            next_cyc();
        end
        idle_in();
        at_neg();
        chk("mul stall_cnt", hz.stall_cnt, 5);
        next_cyc();
        hz.id_is_muldiv = 1; hz.id_is_div = 1;
        next_cyc();
        n = 0;
        at_neg();
        while (!hz.pc_write && n < 100) begin
            n++;
            at_neg();
        end
        chk("div2 stall cycles", n, DIV);
        chk("div2 md_start", 32'(hz.md_start), 1);
        next_cyc(); idle_in();
        repeat (9) @(posedge clk);
        #1 rst_n = 0;
        #1;
        chk("abort md_busy", 32'(hz.md_busy), 0);
        chk("abort md_done", 32'(hz.md_done), 0);
        chk("abort stall_cnt", hz.stall_cnt, 0);
        chk("abort id_ex_flush", 32'(hz.id_ex_flush), 1);
        next_cyc(); next_cyc(); rst_n = 1;
        at_neg();
        chk("post md_busy", 32'(hz.md_busy), 0);
        for (int i = 0; i < 3000; i++) begin
            next_cyc();
            rst_n = ($urandom_range(0, 499) != 0);
            hz.id_rs_addr = 5'($urandom_range(0, 3));
            hz.id_rt_addr = 5'($urandom_range(0, 3));
            hz.ex_rt_addr = 5'($urandom_range(0, 3));
            hz.id_uses_rs = 1'($urandom);
            hz.id_uses_rt = 1'($urandom);
            hz.ex_mem_read = ($urandom_range(0, 2) == 0);
            hz.ex_branch_taken = ($urandom_range(0, 7) == 0);
            hz.id_is_muldiv = ($urandom_range(0, 5) == 0);
            hz.id_is_div = 1'($urandom);
            hz.id_reads_hilo = ($urandom_range(0, 3) == 0);
        end
        next_cyc();
        at_neg();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
